// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the Tamagotchi blocks: default clock rate,
// idle levels of the raw board inputs and cycle-count helpers.
package tamagotchi_pkg;

    localparam int DEF_CLK_HZ = 50_000_000;

    // Raw board inputs as they arrive from the pins.
    typedef struct packed {
        logic btn_n;
        logic luz;
        logic sonido;
    } raw_in_t;

    // Level each raw input shows when nothing is happening:
    // button released (active-low), no light, no sound.
    localparam raw_in_t RAW_IDLE = '{
        btn_n:  1'b1,
        luz:    1'b0,
        sonido: 1'b0
    };

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // Terminal count of a prescaler dividing clk_hz down to div Hz.
    function automatic int hz_to_tc(input int clk_hz, input int div);
        return (clk_hz / div) - 1;
    endfunction

endpackage

// File: rtl/tamagotchi_debounce.sv
// Counter debouncer for one already-synchronised level.
// Ports: clk, rst (async, active-high), din (sync level),
//        dout (debounced level), rise (1-cycle pulse with dout rising).
module tamagotchi_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    // Any cycle where din matches stable restarts the window, so
    // only a level held for DB_CYCLES consecutive cycles is accepted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (din != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = din;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign dout = stable_q;
    assign rise = rise_q;

endmodule

// File: rtl/tamagotchi_input_cond.sv
// Input conditioning ahead of the Tamagotchi FSM: sync + debounce of
// button and light, sound pulse stretch, 1 Hz tick and long-press.
// Ports: clk, rst (async, active-high), btn_raw_n, luz_raw, sonido_raw,
//        test_mode (faster tick) -> boton_interaccion, boton_pulse,
//        boton_long, sensor_luz, sensor_sonido, tick (all registered).
module tamagotchi_input_cond
    import tamagotchi_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int DEBOUNCE_MS  = 20,
    parameter int SND_HOLD_MS  = 100,
    parameter int LONGPRESS_S  = 3,
    parameter int TEST_SPEEDUP = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_n,
    input  logic luz_raw,
    input  logic sonido_raw,
    input  logic test_mode,
    output logic boton_interaccion,
    output logic boton_pulse,
    output logic boton_long,
    output logic sensor_luz,
    output logic sensor_sonido,
    output logic tick
);

    localparam int DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int HOLD_CYCLES = ms_to_cycles(CLK_HZ, SND_HOLD_MS);

    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int PW = $clog2(CLK_HZ) + 1;
    localparam int LW = $clog2(LONGPRESS_S) + 1;

    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] TC_NORMAL = PW'(hz_to_tc(CLK_HZ, 1));
    localparam logic [PW-1:0] TC_FAST   = PW'(hz_to_tc(CLK_HZ, TEST_SPEEDUP));
    localparam logic [LW-1:0] LP_MAX    = LW'(LONGPRESS_S);

    // Two-stage synchronisers, reset to the idle input levels.
    raw_in_t sync1_q, sync1_d;
    raw_in_t sync2_q, sync2_d;

    always_comb begin
        sync1_d = '{
            btn_n:  btn_raw_n,
            luz:    luz_raw,
            sonido: sonido_raw
        };
        sync2_d = sync1_q;
    end

    // Debounced button and light levels.
    logic btn_sync;
    logic btn_lvl;
    logic btn_rise;
    logic luz_lvl;
    logic luz_rise_unused;

    assign btn_sync = ~sync2_q.btn_n;

    tamagotchi_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_btn (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_sync),
        .dout (btn_lvl),
        .rise (btn_rise)
    );

    tamagotchi_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_luz (
        .clk  (clk),
        .rst  (rst),
        .din  (sync2_q.luz),
        .dout (luz_lvl),
        .rise (luz_rise_unused)
    );

    // Sound stretch: every sampled high reloads the hold counter, so
    // a burst of spikes closer than the hold time reads as one level.
    logic [HW-1:0] snd_cnt_q, snd_cnt_d;
    logic          snd_q, snd_d;

    always_comb begin
        snd_cnt_d = snd_cnt_q;
        if (sync2_q.sonido) begin
            snd_cnt_d = HOLD_LOAD;
        end else if (snd_cnt_q != '0) begin
            snd_cnt_d = snd_cnt_q - 1'b1;
        end
        snd_d = sync2_q.sonido | (snd_cnt_q != '0);
    end

    // Tick prescaler. Using >= lets a counter that is already past a
    // freshly lowered terminal count wrap on the next cycle.
    logic [PW-1:0] pre_q, pre_d;
    logic [PW-1:0] tc;
    logic          at_tc;
    logic          tick_q, tick_d;

    always_comb begin
        tc     = test_mode ? TC_FAST : TC_NORMAL;
        at_tc  = (pre_q >= tc);
        pre_d  = at_tc ? '0 : pre_q + 1'b1;
        tick_d = at_tc;
    end

    // Long press: count ticks seen while the debounced button is down,
    // saturate so the event fires once per press.
    logic [LW-1:0] lp_q, lp_d;
    logic          long_q, long_d;

    always_comb begin
        lp_d   = lp_q;
        long_d = 1'b0;
        if (!btn_lvl) begin
            lp_d = '0;
        end else if (tick_q && (lp_q != LP_MAX)) begin
            lp_d   = lp_q + 1'b1;
            long_d = (lp_q == LP_MAX - 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= RAW_IDLE;
            sync2_q   <= RAW_IDLE;
            snd_cnt_q <= '0;
            snd_q     <= 1'b0;
            pre_q     <= '0;
            tick_q    <= 1'b0;
            lp_q      <= '0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            snd_cnt_q <= snd_cnt_d;
            snd_q     <= snd_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            lp_q      <= lp_d;
            long_q    <= long_d;
        end
    end

    assign boton_interaccion = btn_lvl;
    assign boton_pulse       = btn_rise;
    assign boton_long        = long_q;
    assign sensor_luz        = luz_lvl;
    assign sensor_sonido     = snd_q;
    assign tick              = tick_q;

endmodule
